// File: rtl/result_packetizer_pkg.sv
// Accelerator host-protocol constants shared by the UART command decoder and the
// result packetizer: frame bytes and packetizer FSM state encoding.
package result_packetizer_pkg;

   localparam logic [7:0] PKT_HDR_BYTE   = 8'hA5;
   localparam logic [7:0] PKT_CMD_RESULT = 8'h81;

   localparam int STATE_W = 4;

   localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
   localparam logic [STATE_W-1:0] ST_HDR     = 4'd1;
   localparam logic [STATE_W-1:0] ST_CMD     = 4'd2;
   localparam logic [STATE_W-1:0] ST_LEN     = 4'd3;
   localparam logic [STATE_W-1:0] ST_FETCH   = 4'd4;
   localparam logic [STATE_W-1:0] ST_WAIT    = 4'd5;
   localparam logic [STATE_W-1:0] ST_PAYLOAD = 4'd6;
   localparam logic [STATE_W-1:0] ST_CSUM    = 4'd7;
   localparam logic [STATE_W-1:0] ST_DONE    = 4'd8;

   // States in which a byte is offered to the UART transmitter.
   function automatic logic is_tx_state(input logic [STATE_W-1:0] st);
      return (st == ST_HDR) || (st == ST_CMD) || (st == ST_LEN) ||
             (st == ST_PAYLOAD) || (st == ST_CSUM);
   endfunction

endpackage

// File: rtl/result_packetizer.sv
// Streams a block of 32-bit C-memory words to the UART as a framed packet:
// HDR, CMD, LEN, little-endian payload, XOR checksum over everything but HDR.
module result_packetizer
   import result_packetizer_pkg::*;
#(
   parameter int          ADDR_W   = 6,
   parameter logic [7:0]  HDR_BYTE = PKT_HDR_BYTE,
   parameter logic [7:0]  CMD_BYTE = PKT_CMD_RESULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        word_count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [31:0]       mem_rd_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

   logic [STATE_W-1:0] state_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [7:0]         remaining_r;
   logic [31:0]        word_r;
   logic [1:0]         byte_idx_r;
   logic [7:0]         csum_r;
   logic               xfer;

   // All outputs decode straight from registered state, so tx_data cannot move
   // while a byte is stalled on tx_ready.
   assign tx_valid    = is_tx_state(state_r);
   assign xfer        = tx_valid && tx_ready;
   assign mem_rd_en   = (state_r == ST_FETCH);
   assign mem_rd_addr = addr_r;
   assign busy        = (state_r != ST_IDLE) && (state_r != ST_DONE);
   assign done        = (state_r == ST_DONE);

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      tx_data = '0;
      case (state_r)
         ST_HDR:     tx_data = HDR_BYTE;
         ST_CMD:     tx_data = CMD_BYTE;
         ST_LEN:     tx_data = remaining_r;
         ST_PAYLOAD: tx_data = word_r[{byte_idx_r, 3'b000} +: 8];
         ST_CSUM:    tx_data = csum_r;
         default:    tx_data = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= '0;
         remaining_r <= '0;
         word_r      <= '0;
         byte_idx_r  <= '0;
         csum_r      <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  addr_r      <= base_addr;
                  remaining_r <= word_count;
                  csum_r      <= '0;
                  byte_idx_r  <= '0;
                  state_r     <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (xfer) state_r <= ST_CMD;
            end
            ST_CMD: begin
               if (xfer) begin
                  csum_r  <= csum_r ^ CMD_BYTE;
                  state_r <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (xfer) begin
                  csum_r  <= csum_r ^ remaining_r;
                  state_r <= (remaining_r != 8'd0) ? ST_FETCH : ST_CSUM;
               end
            end
            ST_FETCH: state_r <= ST_WAIT;
            ST_WAIT: begin
               word_r  <= mem_rd_data;
               state_r <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               if (xfer) begin
                  csum_r <= csum_r ^ tx_data;
                  if (byte_idx_r == 2'd3) begin
                     byte_idx_r  <= '0;
                     remaining_r <= remaining_r - 8'd1;
                     addr_r      <= addr_r + ADDR_W'(1);
                     state_r     <= (remaining_r == 8'd1) ? ST_CSUM : ST_FETCH;
                  end else begin
                     byte_idx_r <= byte_idx_r + 2'd1;
                  end
               end
            end
            ST_CSUM: begin
               if (xfer) state_r <= ST_DONE;
            end
            ST_DONE:  state_r <= ST_IDLE;
            default:  state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_packetizer.sv
// Scoreboard bench for result_packetizer: stimulus queues expected bytes and
// read addresses, a negedge monitor pops and compares them as the DUT emits.
module tb_result_packetizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  base_addr;
   logic [7:0]  word_count;
   logic        mem_rd_en;
   logic [5:0]  mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   result_packetizer #(.ADDR_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .word_count  (word_count),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .busy        (busy),
      .done        (done)
   );

   logic [31:0] mem [64];

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   int n_vec    = 0;
   int n_fail   = 0;
   int byte_cnt = 0;
   int done_cnt = 0;
   logic [7:0] exp_q [$];
   logic [5:0] addr_q [$];
   logic [7:0] held;
   bit         held_v = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: byte scoreboard, read-address scoreboard, stall stability, done count.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v = 1'b0;
         end else begin
            if (tx_valid && !tx_ready) begin
               if (held_v) check("stall_hold", {24'h0, tx_data}, {24'h0, held});
               held   = tx_data;
               held_v = 1'b1;
            end else if (held_v) begin
               check("stall_valid", {31'h0, tx_valid}, 32'h1);
               if (tx_valid) check("stall_release", {24'h0, tx_data}, {24'h0, held});
               held_v = 1'b0;
            end
            if (tx_valid && tx_ready) begin
               byte_cnt++;
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got %h expected none", tx_data);
               end else begin
                  check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
               end
            end
            if (mem_rd_en) begin
               if (addr_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_rd: got addr %0d expected no read", mem_rd_addr);
               end else begin
                  check("rd_addr", {26'h0, mem_rd_addr}, {26'h0, addr_q.pop_front()});
               end
            end
            if (done) done_cnt++;
         end
      end
   end

   // Reference frame model, independent of the DUT's internal structure.
   task automatic push_frame(input logic [5:0] b, input logic [7:0] c);
      logic [7:0]  cs;
      logic [31:0] w;
      logic [5:0]  a;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h81);
      exp_q.push_back(c);
      cs = 8'h81 ^ c;
      a  = b;
      for (int i = 0; i < int'(c); i++) begin
         addr_q.push_back(a);
         w = mem[a];
         for (int k = 0; k < 4; k++) begin
            exp_q.push_back(w[8*k +: 8]);
            cs = cs ^ w[8*k +: 8];
         end
         a = a + 6'd1;
      end
      exp_q.push_back(cs);
   endtask

   // Called at #1 after a rising edge; returns at the same phase.
   task automatic send(input logic [5:0] b, input logic [7:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      @(posedge clk);
      #1 start   = 1'b0;
      check("busy_after_start", {31'h0, busy}, 32'h1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt >= target) break;
         @(negedge clk);
      end
      repeat (6) @(posedge clk);
      #1;
      check("done_count", done_cnt, target);
      check("bytes_left", exp_q.size(), 0);
      check("reads_left", addr_q.size(), 0);
      check("busy_idle", {31'h0, busy}, 32'h0);
   endtask

   task automatic wait_bytes(input int target);
      for (int i = 0; i < 3000; i++) begin
         if (byte_cnt >= target) break;
         @(negedge clk);
      end
   endtask

   initial begin
      int b0;
      rst_n       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      word_count  = '0;
      tx_ready    = 1'b1;
      mem_rd_data = '0;
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i * 32'h0101_0101;
      mem[0]  = 32'h1234_5678;
      mem[4]  = 32'hDEAD_BEEF;
      mem[5]  = 32'h0BAD_F00D;
      mem[63] = 32'hA1B2_C3D4;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
      check("rst_rd_addr", {26'h0, mem_rd_addr}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // One word: hand-computed frame A5 81 01 78 56 34 12 88.
      exp_q = '{8'hA5, 8'h81, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h88};
      addr_q.push_back(6'd0);
      send(6'd0, 8'd1);
      wait_done(1);

      // Empty frame: A5 81 00 81, no memory read.
      exp_q = '{8'hA5, 8'h81, 8'h00, 8'h81};
      send(6'd9, 8'd0);
      wait_done(2);

      // Two words with a 5-cycle stall on the second payload byte.
      b0 = byte_cnt;
      push_frame(6'd4, 8'd2);
      send(6'd4, 8'd2);
      wait_bytes(b0 + 4);
      @(posedge clk);
      #1 tx_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_done(3);
      check("stall_frame_len", byte_cnt - b0, 12);

      // Address wrap 63 -> 0.
      push_frame(6'd63, 8'd2);
      send(6'd63, 8'd2);
      wait_done(4);

      // Start pulsed mid-payload must be ignored.
      b0 = byte_cnt;
      push_frame(6'd10, 8'd3);
      send(6'd10, 8'd3);
      wait_bytes(b0 + 6);
      @(posedge clk);
      #1;
      base_addr  = 6'd30;
      word_count = 8'd5;
      start      = 1'b1;
      @(posedge clk);
      #1 start   = 1'b0;
      wait_done(5);
      check("ignored_start_len", byte_cnt - b0, 16);

      // Reset right after the LEN byte abandons the frame.
      b0 = byte_cnt;
      push_frame(6'd20, 8'd2);
      send(6'd20, 8'd2);
      wait_bytes(b0 + 3);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_rd_en", {31'h0, mem_rd_en}, 32'h0);
      check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
      exp_q.delete();
      addr_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      b0 = byte_cnt;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_bytes", byte_cnt - b0, 0);
      check("post_rst_done", done_cnt, 5);
      push_frame(6'd20, 8'd2);
      send(6'd20, 8'd2);
      wait_done(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
